core_id_scoreboard: RTL and testbench
=====================================

CORE_ID_SCOREBOARD -- requirements
Module: core_id_scoreboard

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, meaning the maximum number of in-flight instructions between ID issue and WB retire (power of two, 2..8).
REQ-002 SHALL have ports as follows:
- clk  in  1  clock, all state on rising edge.
- rest  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  ID holds a valid decoded instruction and EX can accept it.
- issue_rd  in  5  destination register.
- issue_reg_write  in  1  instruction writes issue_rd.
- issue_csr  in  12  destination CSR.
- issue_csr_write  in  1  instruction writes issue_csr.
- id_rs1, id_rs2  in  5 each  source registers of the ID instruction.
- id_rs1_valid, id_rs2_valid  in  1 each  source is actually read.
- id_csr  in  12  CSR read by the ID instruction.
- id_csr_read  in  1  ID instruction reads id_csr.
- retire_valid  in  1  WB commits the oldest in-flight instruction (wd_valid and wd_ready).
- ex_flush_en  in  1  EX flush.
- ex_flush_num  in  2  number of youngest entries to discard on flush (0..2).
- id_stall  out  1  ID must hold its instruction (gates fd_ready and de_valid).
- issue_fire  out  1  the instruction is recorded this cycle.
- sb_count  out  $clog2(SB_DEPTH)+1  in-flight count.
- sb_full, sb_empty  out  1 each  count == SB_DEPTH, count == 0.

Function
REQ-003 SHALL hold an in-order circular queue of entries {rd, reg_write, csr, csr_write} with head (oldest), tail and count registers.
REQ-004 SHALL define issue_fire = issue_valid && !id_stall && !ex_flush_en, combinationally.
REQ-005 SHALL push one entry at tail on issue_fire; tail SHALL wrap from SB_DEPTH-1 to 0.
REQ-006 SHALL pop the head entry on retire_valid; head SHALL wrap from SB_DEPTH-1 to 0.
REQ-007 SHALL, on ex_flush_en, move tail back by ex_flush_num modulo SB_DEPTH, discarding the youngest entries; no push SHALL occur in the same cycle.
REQ-008 SHALL apply pop and flush in the same cycle: count_next = count - retire_valid - ex_flush_num.
REQ-009 SHALL update count_next = count + 1 - 1 on simultaneous push and pop, leaving count unchanged.
REQ-010 SHALL assert a RAW hazard when id_rs1_valid and id_rs1 != 0 match the rd of any valid entry with reg_write set, and likewise for rs2.
REQ-011 SHALL assert a CSR hazard when id_csr_read and id_csr match the csr of any valid entry with csr_write set.
REQ-012 SHALL treat an entry with rd == 0 as a non-hazard.
REQ-013 SHALL keep the head entry hazard-active during the cycle it retires (no WB bypass); the stall clears the following cycle.
REQ-014 SHALL drive id_stall = raw_hazard || csr_hazard || sb_full, where sb_full means full at cycle start; a same-cycle pop SHALL NOT unblock a push.
REQ-015 SHALL ignore retire_valid when sb_empty; count SHALL never underflow.
REQ-016 SHALL require ex_flush_num <= count - retire_valid; violating this is a checker error with no defined behaviour.
REQ-017 SHALL have all outputs other than issue_fire and id_stall registered or derived only from registered state; issue_fire and id_stall are combinational from ID inputs.

Reset
REQ-018 SHALL, while rest is low, clear head, tail and count to 0 and invalidate all entries, so that sb_empty=1, sb_full=0, sb_count=0, id_stall=0 and issue_fire=0 when issue_valid=0.
REQ-019 SHALL discard all in-flight entries if rest is asserted mid-operation; no partial state survives.
REQ-020 SHALL leave entry payload storage unreset; only the valid state is reset.

Structure
REQ-021 SHALL place the sb_entry_t typedef and the SB_DEPTH default in the shared core package, next to the existing ALU_OP and ISTR constants.
REQ-022 SHALL use one sub-module, core_sb_match, to hold the per-entry comparator vector (rs1, rs2, csr against all valid entries), instantiated once.
REQ-023 SHALL keep the block to 120-400 lines of RTL, with no memories inferred beyond flops.

Verification
REQ-024 Reset then issue rd=5 (issue_valid=1): sb_count=1 next cycle; ID with rs1=5 -> id_stall=1; retire_valid=1 -> id_stall still 1 that cycle, 0 the next.
REQ-025 Issue 4 instructions rd=1..4 without retire: sb_full=1, and a 5th issue_valid gives issue_fire=0; the same cycle with retire_valid=1 still gives issue_fire=0; the next cycle gives issue_fire=1.
REQ-026 With 3 entries, drive ex_flush_en=1 with ex_flush_num=2 and retire_valid=1: sb_count=0 and sb_empty=1 next cycle; issue_valid in the flush cycle gives issue_fire=0.
REQ-027 Fill and drain 10 entries in sequence: head and tail wrap past SB_DEPTH-1 correctly, and the hazard on rd=7 issued as the 6th entry is detected.
REQ-028 Issue rd=0 with reg_write=1, then ID rs1=0 -> id_stall=0; issue csr=0x300 with csr_write=1, then id_csr_read=1 with id_csr=0x300 -> id_stall=1, and with id_csr=0x341 -> id_stall=0.
REQ-029 With 2 entries, pulse rest low asynchronously mid-cycle: sb_count=0 and id_stall=0 immediately; after release, retire_valid=1 leaves count at 0.

Source files
------------

// File: rtl/core_id_scoreboard_pkg.sv
// Shared core package: ALU/instruction constants plus the ID scoreboard
// entry type and default depth.
//   sb_entry_t       : one in-flight instruction's destination info
//   SB_DEPTH_DEFAULT : default scoreboard depth (power of two, 2..8)
package core_id_scoreboard_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;

  localparam logic [31:0] ISTR_NOP = 32'h0000_0013;

  localparam int SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_write;
    logic [11:0] csr;
    logic        csr_write;
  } sb_entry_t;

endpackage

// File: rtl/core_id_scoreboard_if.sv
// Scoreboard bundle between the pipeline (ID/EX/WB) and the scoreboard.
//   master : pipeline side, drives issue/ID source/retire/flush signals
//   slave  : scoreboard side, drives id_stall, issue_fire and status
interface core_id_scoreboard_if
  import core_id_scoreboard_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             issue_reg_write;
  logic [11:0]      issue_csr;
  logic             issue_csr_write;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_valid;
  logic             id_rs2_valid;
  logic [11:0]      id_csr;
  logic             id_csr_read;
  logic             retire_valid;
  logic             ex_flush_en;
  logic [1:0]       ex_flush_num;
  logic             id_stall;
  logic             issue_fire;
  logic [CNT_W-1:0] sb_count;
  logic             sb_full;
  logic             sb_empty;

  modport master (
    output issue_valid, issue_rd, issue_reg_write, issue_csr, issue_csr_write,
    output id_rs1, id_rs2, id_rs1_valid, id_rs2_valid, id_csr, id_csr_read,
    output retire_valid, ex_flush_en, ex_flush_num,
    input  id_stall, issue_fire, sb_count, sb_full, sb_empty
  );

  modport slave (
    input  issue_valid, issue_rd, issue_reg_write, issue_csr, issue_csr_write,
    input  id_rs1, id_rs2, id_rs1_valid, id_rs2_valid, id_csr, id_csr_read,
    input  retire_valid, ex_flush_en, ex_flush_num,
    output id_stall, issue_fire, sb_count, sb_full, sb_empty
  );

endinterface

// File: rtl/core_sb_match.sv
// Per-entry hazard comparators: checks the ID instruction's rs1/rs2/csr
// sources against every valid scoreboard entry.
//   entries/entry_valid : scoreboard contents and per-slot valid mask
//   id_*                : ID source operands and their use flags
//   raw_hazard          : a GPR source is pending in some entry
//   csr_hazard          : the CSR source is pending in some entry
module core_sb_match
  import core_id_scoreboard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      entry_valid,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_valid,
  input  logic                  id_rs2_valid,
  input  logic [11:0]           id_csr,
  input  logic                  id_csr_read,
  output logic                  raw_hazard,
  output logic                  csr_hazard
);
  logic [DEPTH-1:0] rs1_hit;
  logic [DEPTH-1:0] rs2_hit;
  logic [DEPTH-1:0] csr_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    // x0 is never a real destination, so an rd of 0 cannot create a hazard.
    logic gpr_pending;
    assign gpr_pending = entry_valid[gi] && entries[gi].reg_write
                         && (entries[gi].rd != 5'd0);
    assign rs1_hit[gi] = gpr_pending && id_rs1_valid && (id_rs1 == entries[gi].rd);
    assign rs2_hit[gi] = gpr_pending && id_rs2_valid && (id_rs2 == entries[gi].rd);
    assign csr_hit[gi] = entry_valid[gi] && entries[gi].csr_write
                         && id_csr_read && (id_csr == entries[gi].csr);
  end

  assign raw_hazard = (|rs1_hit) || (|rs2_hit);
  assign csr_hazard = |csr_hit;

endmodule

// File: rtl/core_id_scoreboard.sv
// In-order scoreboard tracking instructions between ID issue and WB retire.
// Stalls ID on RAW (GPR) or CSR hazards against in-flight destinations, or
// when the queue is full.
//   clk  : clock, all state on rising edge
//   rest : asynchronous active-low reset
//   sb   : scoreboard bundle (slave side)
module core_id_scoreboard
  import core_id_scoreboard_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input logic                 clk,
  input logic                 rest,
  core_id_scoreboard_if.slave sb
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // Payload storage is deliberately not reset; validity comes from head/count.
  sb_entry_t [SB_DEPTH-1:0] entries_reg;
  logic [SB_DEPTH-1:0]      entry_valid;

  logic push, pop, full_w, empty_w;
  logic raw_hazard, csr_hazard, stall_w;
  logic [1:0] flush_amt;

  assign full_w  = (count_reg == CNT_W'(SB_DEPTH));
  assign empty_w = (count_reg == '0);

  // Retire on an empty queue is ignored so count cannot underflow.
  assign pop       = sb.retire_valid && !empty_w;
  assign flush_amt = sb.ex_flush_en ? sb.ex_flush_num : 2'd0;

  // Stall uses full-at-cycle-start, so a same-cycle retire cannot let a push in.
  assign stall_w = raw_hazard || csr_hazard || full_w;
  assign push    = sb.issue_valid && !stall_w && !sb.ex_flush_en;

  // A slot is valid when its distance from head is below count. The head
  // slot stays valid through its retire cycle, so there is no WB bypass.
  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] offset;
    assign offset          = PTR_W'(gi) - head_reg;
    assign entry_valid[gi] = ({1'b0, offset} < count_reg);
  end

  core_sb_match #(.DEPTH(SB_DEPTH)) u_match (
    .entries      (entries_reg),
    .entry_valid  (entry_valid),
    .id_rs1       (sb.id_rs1),
    .id_rs2       (sb.id_rs2),
    .id_rs1_valid (sb.id_rs1_valid),
    .id_rs2_valid (sb.id_rs2_valid),
    .id_csr       (sb.id_csr),
    .id_csr_read  (sb.id_csr_read),
    .raw_hazard   (raw_hazard),
    .csr_hazard   (csr_hazard)
  );

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop) - CNT_W'(flush_amt);
    if (pop) head_next = head_reg + PTR_W'(1);
    // Truncating the flush amount to the pointer width gives the modulo
    // wrap for small depths (depth 2 flushing 2 leaves tail in place).
    if (sb.ex_flush_en) tail_next = tail_reg - PTR_W'(sb.ex_flush_num);
    else if (push)      tail_next = tail_reg + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entries_reg[tail_reg] <= '{rd:        sb.issue_rd,
                                 reg_write: sb.issue_reg_write,
                                 csr:       sb.issue_csr,
                                 csr_write: sb.issue_csr_write};
    end
  end

  assign sb.id_stall   = stall_w;
  assign sb.issue_fire = push;
  assign sb.sb_count   = count_reg;
  assign sb.sb_full    = full_w;
  assign sb.sb_empty   = empty_w;

endmodule

// File: tb/tb_core_id_scoreboard.sv
// Directed bench for core_id_scoreboard (SB_DEPTH = 4).
module tb_core_id_scoreboard;
  import core_id_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rest = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  core_id_scoreboard_if #(.SB_DEPTH(4)) sb_if ();

  core_id_scoreboard #(.SB_DEPTH(4)) dut (
    .clk  (clk),
    .rest (rest),
    .sb   (sb_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    sb_if.issue_valid     = 1'b0;
    sb_if.issue_rd        = 5'd0;
    sb_if.issue_reg_write = 1'b0;
    sb_if.issue_csr       = 12'h000;
    sb_if.issue_csr_write = 1'b0;
    sb_if.id_rs1          = 5'd0;
    sb_if.id_rs2          = 5'd0;
    sb_if.id_rs1_valid    = 1'b0;
    sb_if.id_rs2_valid    = 1'b0;
    sb_if.id_csr          = 12'h000;
    sb_if.id_csr_read     = 1'b0;
    sb_if.retire_valid    = 1'b0;
    sb_if.ex_flush_en     = 1'b0;
    sb_if.ex_flush_num    = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic rw,
                           input logic [11:0] csr, input logic cw);
    sb_if.issue_valid     = 1'b1;
    sb_if.issue_rd        = rd;
    sb_if.issue_reg_write = rw;
    sb_if.issue_csr       = csr;
    sb_if.issue_csr_write = cw;
  endtask

  initial begin
    clear_inputs();
    #1 rest = 1'b0;
    #2;
    // Reset state
    check("rst_count", 32'(sb_if.sb_count), 0);
    check("rst_empty", 32'(sb_if.sb_empty), 1);
    check("rst_full",  32'(sb_if.sb_full), 0);
    check("rst_stall", 32'(sb_if.id_stall), 0);
    check("rst_fire",  32'(sb_if.issue_fire), 0);
    #9 rest = 1'b1;

    // Issue rd=5, RAW stall, stall held through retire cycle
    tick();
    set_issue(5'd5, 1'b1, 12'h000, 1'b0);
    #1 check("i5_fire", 32'(sb_if.issue_fire), 1);
    tick();
    clear_inputs();
    #1 check("i5_count", 32'(sb_if.sb_count), 1);
    sb_if.id_rs1 = 5'd5; sb_if.id_rs1_valid = 1'b1;
    #1 check("raw5_stall", 32'(sb_if.id_stall), 1);
    sb_if.retire_valid = 1'b1;
    #1 check("raw5_ret_stall", 32'(sb_if.id_stall), 1);
    tick();
    sb_if.retire_valid = 1'b0;
    #1 check("raw5_clear", 32'(sb_if.id_stall), 0);
    check("raw5_empty", 32'(sb_if.sb_empty), 1);
    clear_inputs();

    // Fill to full, blocked 5th issue even with same-cycle retire
    for (int i = 1; i <= 4; i++) begin
      set_issue(5'(i), 1'b1, 12'h000, 1'b0);
      tick();
    end
    clear_inputs();
    #1 check("full_count", 32'(sb_if.sb_count), 4);
    check("full_flag", 32'(sb_if.sb_full), 1);
    set_issue(5'd9, 1'b1, 12'h000, 1'b0);
    #1 check("full_fire", 32'(sb_if.issue_fire), 0);
    sb_if.retire_valid = 1'b1;
    #1 check("full_ret_fire", 32'(sb_if.issue_fire), 0);
    tick();
    sb_if.retire_valid = 1'b0;
    #1 check("after_ret_fire", 32'(sb_if.issue_fire), 1);
    check("after_ret_cnt", 32'(sb_if.sb_count), 3);
    tick();
    clear_inputs();
    #1 check("refill_count", 32'(sb_if.sb_count), 4);
    sb_if.retire_valid = 1'b1;
    repeat (4) tick();
    sb_if.retire_valid = 1'b0;
    #1 check("drain_empty", 32'(sb_if.sb_empty), 1);
    // Retire on empty must not underflow
    sb_if.retire_valid = 1'b1;
    tick();
    sb_if.retire_valid = 1'b0;
    #1 check("underflow_cnt", 32'(sb_if.sb_count), 0);

    // Flush 2 plus retire 1 with 3 entries
    for (int i = 10; i <= 12; i++) begin
      set_issue(5'(i), 1'b1, 12'h000, 1'b0);
      tick();
    end
    set_issue(5'd15, 1'b1, 12'h000, 1'b0);
    sb_if.ex_flush_en = 1'b1; sb_if.ex_flush_num = 2'd2; sb_if.retire_valid = 1'b1;
    #1 check("flush_fire", 32'(sb_if.issue_fire), 0);
    tick();
    clear_inputs();
    #1 check("flush_count", 32'(sb_if.sb_count), 0);
    check("flush_empty", 32'(sb_if.sb_empty), 1);

    // Flush 1 of 2: youngest gone, oldest still pending
    set_issue(5'd13, 1'b1, 12'h000, 1'b0); tick();
    set_issue(5'd14, 1'b1, 12'h000, 1'b0); tick();
    clear_inputs();
    sb_if.ex_flush_en = 1'b1; sb_if.ex_flush_num = 2'd1;
    tick();
    clear_inputs();
    #1 check("flush1_count", 32'(sb_if.sb_count), 1);
    sb_if.id_rs1_valid = 1'b1; sb_if.id_rs1 = 5'd14;
    #1 check("flush1_rd14", 32'(sb_if.id_stall), 0);
    sb_if.id_rs1 = 5'd13;
    #1 check("flush1_rd13", 32'(sb_if.id_stall), 1);
    clear_inputs();
    sb_if.retire_valid = 1'b1; tick();
    clear_inputs();

    // Stream 10 entries with wrap; entry 6 has rd=7
    for (int k = 1; k <= 10; k++) begin
      set_issue((k == 6) ? 5'd7 : 5'(20 + k), 1'b1, 12'h000, 1'b0);
      sb_if.retire_valid = (k > 3);
      #1 check("stream_fire", 32'(sb_if.issue_fire), 1);
      tick();
      clear_inputs();
      #1 check("stream_count", 32'(sb_if.sb_count), (k < 3) ? k : 3);
      if (k == 6 || k == 10) begin
        sb_if.id_rs2_valid = 1'b1; sb_if.id_rs2 = 5'd7;
        #1 check("stream_rd7", 32'(sb_if.id_stall), (k == 6) ? 1 : 0);
        clear_inputs();
      end
    end
    sb_if.retire_valid = 1'b1;
    repeat (3) tick();
    clear_inputs();
    #1 check("stream_empty", 32'(sb_if.sb_empty), 1);

    // rd=0 never hazards; CSR hazard only on matching address
    set_issue(5'd0, 1'b1, 12'h000, 1'b0); tick();
    set_issue(5'd0, 1'b0, 12'h300, 1'b1); tick();
    clear_inputs();
    sb_if.id_rs1_valid = 1'b1; sb_if.id_rs1 = 5'd0;
    #1 check("rd0_stall", 32'(sb_if.id_stall), 0);
    sb_if.id_csr_read = 1'b1; sb_if.id_csr = 12'h300;
    #1 check("csr300_stall", 32'(sb_if.id_stall), 1);
    sb_if.id_csr = 12'h341;
    #1 check("csr341_stall", 32'(sb_if.id_stall), 0);
    sb_if.id_csr = 12'h300; sb_if.id_csr_read = 1'b0;
    #1 check("csr_noread", 32'(sb_if.id_stall), 0);
    check("csr_count", 32'(sb_if.sb_count), 2);

    // Asynchronous reset mid-cycle with 2 entries
    sb_if.id_csr_read = 1'b1;
    #1 rest = 1'b0;
    #1 check("arst_count", 32'(sb_if.sb_count), 0);
    check("arst_stall", 32'(sb_if.id_stall), 0);
    #1 rest = 1'b1;
    clear_inputs();
    sb_if.retire_valid = 1'b1;
    tick();
    sb_if.retire_valid = 1'b0;
    #1 check("arst_ret_cnt", 32'(sb_if.sb_count), 0);
    set_issue(5'd3, 1'b1, 12'h000, 1'b0);
    tick();
    clear_inputs();
    #1 check("post_rst_cnt", 32'(sb_if.sb_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
